gpio_checkpoint_capture: RTL

Synthesizable observer for firmware checkpoints that the management SoC drives onto the user-project pads as {code[5:0] = mprj_io[37:32], data[31:0] = mprj_io[31:0]}. It synchronizes the pad bus and waits for each new non-zero code to settle. It then captures {code, data} into a FIFO that a consumer drains over a valid/ready port. It sits on the pad side, on a test board or in a companion user project, and consumes the pattern the firmware tests produce.

---
 rtl/gpio_checkpoint_capture.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/gpio_checkpoint_capture.sv
// gpio_checkpoint_capture
// Watches the firmware checkpoint pattern on the user-project pads
// ({code[5:0], data[31:0]}). The pads are synchronized and each new non-zero
// code is waited on until it settles. {code, data} is then queued in a small
// show-ahead FIFO that a consumer drains over a valid/ready port.
module gpio_checkpoint_capture #(
    parameter int STABLE_CYCLES = 4,  // 2..15
    parameter int DEPTH         = 8   // power of 2, 2..16
) (
    input  logic        clock,
    input  logic        resetb,
    input  logic [37:0] pad_in,
    input  logic        enable,
    output logic        rd_valid,
    input  logic        rd_ready,
    output logic [5:0]  rd_code,
    output logic [31:0] rd_data,
    output logic [4:0]  fill,
    output logic        overflow,
    input  logic        clear_overflow
);

    localparam int         PTR_W     = $clog2(DEPTH);
    localparam logic [3:0] CNT_MAX   = 4'(STABLE_CYCLES);
    // The first synchronizer stage holds the value s2 will show next cycle.
    // Comparing stage 1 against stage 2 therefore gives the same
    // "s2 equals its previous value" information one cycle earlier. That is
    // why the settle point sits one count below STABLE_CYCLES-1.
    localparam logic [3:0] SETTLE_AT = 4'(STABLE_CYCLES - 2);
    localparam logic [4:0] FULL_LVL  = 5'(DEPTH);

    logic [37:0]      sync1_q, sync2_q;
    logic [3:0]       stab_cnt_q, stab_cnt_d;
    logic [5:0]       last_code_q, last_code_d;
    logic [37:0]      mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [4:0]       fill_q, fill_d;
    logic             overflow_q, overflow_d;

    logic sample_same, settled, capture_evt, push_req, push_ok, pop, drop;

    // Two-flop synchronizer on the whole pad bus.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            // NOTE: state is always updated with <= so all flops sample pre-edge values.
            sync1_q <= pad_in;
            sync2_q <= sync1_q;
        end
    end

    // Settle detection, capture decision and FIFO push/pop arbitration.
    always_comb begin
        // NOTE: every signal gets a default here so no path can infer a latch.
        stab_cnt_d  = stab_cnt_q;
        last_code_d = last_code_q;

        sample_same = (sync1_q == sync2_q);
        settled     = sample_same && (stab_cnt_q == SETTLE_AT);
        capture_evt = settled && (sync2_q[37:32] != last_code_q);
        push_req    = capture_evt && (sync2_q[37:32] != 6'd0) && enable;
        pop         = (fill_q != 5'd0) && rd_ready;
        push_ok     = push_req && ((fill_q != FULL_LVL) || pop);
        drop        = push_req && !push_ok;

        // Saturating run counter: restarts whenever the sample changes.
        if (!sample_same) begin
            stab_cnt_d = 4'd0;
        end else if (stab_cnt_q != CNT_MAX) begin
            stab_cnt_d = stab_cnt_q + 4'd1;
        end

        // Code 0 and disabled captures still move last_code, so they block a
        // later re-capture of the same code.
        if (capture_evt) begin
            last_code_d = sync2_q[37:32];
        end
    end

    // FIFO bookkeeping: pointers, fill level and sticky overflow.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        fill_d     = fill_q;
        overflow_d = overflow_q;

        // DEPTH is a power of 2, so the pointers wrap by plain overflow.
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        case ({push_ok, pop})
            2'b10:   fill_d = fill_q + 5'd1;
            2'b01:   fill_d = fill_q - 5'd1;
            default: fill_d = fill_q;
        endcase

        // A new drop wins over a simultaneous clear.
        if (drop) begin
            overflow_d = 1'b1;
        end else if (clear_overflow) begin
            overflow_d = 1'b0;
        end
    end

    // Control state registers.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            stab_cnt_q  <= '0;
            last_code_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            fill_q      <= '0;
            overflow_q  <= 1'b0;
        end else begin
            stab_cnt_q  <= stab_cnt_d;
            last_code_q <= last_code_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            fill_q      <= fill_d;
            overflow_q  <= overflow_d;
        end
    end

    // FIFO storage write port.
    // NOTE: the storage array has no reset. Clearing fill and the pointers
    // already empties the FIFO, and the read gating hides stale words.
    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= sync2_q;
        end
    end

    // Show-ahead head entry, forced to zero while the FIFO is empty.
    always_comb begin
        rd_valid = (fill_q != 5'd0);
        rd_code  = 6'd0;
        rd_data  = 32'd0;
        if (rd_valid) begin
            rd_code = mem_q[rd_ptr_q][37:32];
            rd_data = mem_q[rd_ptr_q][31:0];
        end
    end

    assign fill     = fill_q;
    assign overflow = overflow_q;

endmodule
